// File: rtl/prot_sequencer.sv
// rtl/prot_sequencer.sv - per-channel comparator debounce and relay arm/trip/cooldown/lockout sequencer; PROT_AUTO_RETRY_EN enables bounded auto-retry
module prot_sequencer #(
    parameter int NCH          = 2,
    parameter int ARM_CYCLES   = 108,
    parameter int DEBOUNCE     = 3,
    parameter int RETRY_CYCLES = 540,
    parameter int MAX_RETRIES  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           por_done,
    input  logic [NCH-1:0] vin_too_high,
    input  logic [NCH-1:0] vin_not_negative,
    input  logic           fault_clear,
    output logic [NCH-1:0] relay_en,
    output logic [NCH-1:0] lockout,
    output logic [NCH-1:0] vhi_flag,
    output logic [NCH-1:0] vlo_flag,
    output logic           ok_led_en,
    output logic           fault_led_en
);

    typedef enum logic [2:0] {
        ST_ARMING   = 3'd0,
        ST_ON       = 3'd1,
        ST_TRIPPED  = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    localparam int BAD_W = $clog2(DEBOUNCE + 1);
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);
`ifdef PROT_AUTO_RETRY_EN
    localparam int TMR_W = $clog2(RETRY_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
`endif

    logic [NCH-1:0] on_nxt;
    logic [NCH-1:0] lock_nxt;
    logic [NCH-1:0] fault_nxt;
    logic [NCH-1:0] vhi_nxt;
    logic [NCH-1:0] vlo_nxt;

    if (NCH < 1 || NCH > 8 || ARM_CYCLES < 1 || DEBOUNCE < 1 ||
        RETRY_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_cfg
        $error("prot_sequencer: illegal parameter set");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]       hi_sync;
        logic [1:0]       nn_sync;
        logic             hi_s;
        logic             nn_s;
        logic             bad_s;
        logic             trip;
        logic             armed;
        logic [BAD_W-1:0] bad_cnt;
        logic [ARM_W-1:0] arm_cnt;
        state_t           state;
        state_t           state_nxt;
        logic             ch_on;
        logic             ch_lock;
        logic             ch_fault;
        logic             ch_vhi;
        logic             ch_vlo;
`ifdef PROT_AUTO_RETRY_EN
        logic [TMR_W-1:0] timer;
        logic [RTY_W-1:0] retry_cnt;
        logic [RTY_W-1:0] retry_inc;
        logic             timer_done;
`endif

        assign hi_s  = hi_sync[1];
        assign nn_s  = nn_sync[1];
        assign bad_s = hi_s | ~nn_s;
        assign trip  = bad_s && (bad_cnt == BAD_W'(DEBOUNCE - 1));
        assign armed = !bad_s && (arm_cnt == ARM_W'(ARM_CYCLES - 1));
`ifdef PROT_AUTO_RETRY_EN
        assign timer_done = (timer == TMR_W'(RETRY_CYCLES - 1));
        assign retry_inc  = (retry_cnt == RTY_W'(MAX_RETRIES)) ? retry_cnt : retry_cnt + 1'b1;
`endif

        // Synchronisers run free of por_done so inputs are settled when it rises.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hi_sync <= 2'b00;
                nn_sync <= 2'b00;
            end else begin
                hi_sync <= {hi_sync[0], vin_too_high[i]};
                nn_sync <= {nn_sync[0], vin_not_negative[i]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_ARMING;
            end else begin
                state <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            if (!por_done) begin
                state_nxt = ST_ARMING;
            end else begin
                case (state)
                    ST_ARMING:   if (armed) state_nxt = ST_ON;
                    ST_ON:       if (trip) state_nxt = ST_TRIPPED;
`ifdef PROT_AUTO_RETRY_EN
                    ST_TRIPPED:  state_nxt = (retry_inc == RTY_W'(MAX_RETRIES)) ? ST_LOCKOUT : ST_COOLDOWN;
                    ST_COOLDOWN: if (timer_done) state_nxt = ST_ARMING;
`else
                    ST_TRIPPED:  state_nxt = ST_LOCKOUT;
                    ST_COOLDOWN: state_nxt = ST_ARMING;
`endif
                    ST_LOCKOUT:  if (fault_clear) state_nxt = ST_ARMING;
                    default:     state_nxt = ST_ARMING;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bad_cnt   <= '0;
                arm_cnt   <= '0;
`ifdef PROT_AUTO_RETRY_EN
                timer     <= '0;
                retry_cnt <= '0;
`endif
            end else if (!por_done) begin
                bad_cnt   <= '0;
                arm_cnt   <= '0;
`ifdef PROT_AUTO_RETRY_EN
                timer     <= '0;
                retry_cnt <= '0;
`endif
            end else begin
                if (!bad_s) begin
                    bad_cnt <= '0;
                end else if (bad_cnt != BAD_W'(DEBOUNCE)) begin
                    bad_cnt <= bad_cnt + 1'b1;
                end

                if (state == ST_ARMING && state_nxt == ST_ARMING && !bad_s) begin
                    if (arm_cnt != ARM_W'(ARM_CYCLES)) arm_cnt <= arm_cnt + 1'b1;
                end else begin
                    arm_cnt <= '0;
                end
`ifdef PROT_AUTO_RETRY_EN
                // One timer serves both the ON age and the cooldown length.
                if (state_nxt == state && (state == ST_ON || state == ST_COOLDOWN)) begin
                    if (timer != TMR_W'(RETRY_CYCLES)) timer <= timer + 1'b1;
                end else begin
                    timer <= '0;
                end

                if (state == ST_TRIPPED) begin
                    retry_cnt <= retry_inc;
                end else if (state == ST_LOCKOUT && fault_clear) begin
                    retry_cnt <= '0;
                end else if (state == ST_ON && state_nxt == ST_ON && timer_done) begin
                    retry_cnt <= '0;
                end
`endif
            end
        end

        always_comb begin
            ch_on    = (state_nxt == ST_ON);
            ch_lock  = (state_nxt == ST_LOCKOUT);
            ch_fault = (state_nxt == ST_TRIPPED) || (state_nxt == ST_COOLDOWN) ||
                       (state_nxt == ST_LOCKOUT);
            ch_vhi   = vhi_flag[i];
            ch_vlo   = vlo_flag[i];
            // A trip capture outranks a coincident fault_clear.
            if (!por_done) begin
                ch_vhi = 1'b0;
                ch_vlo = 1'b0;
            end else if (state == ST_ON && trip) begin
                ch_vhi = hi_s;
                ch_vlo = ~nn_s;
            end else if (fault_clear) begin
                ch_vhi = 1'b0;
                ch_vlo = 1'b0;
            end
        end

        assign on_nxt[i]    = ch_on;
        assign lock_nxt[i]  = ch_lock;
        assign fault_nxt[i] = ch_fault;
        assign vhi_nxt[i]   = ch_vhi;
        assign vlo_nxt[i]   = ch_vlo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relay_en     <= '0;
            lockout      <= '0;
            vhi_flag     <= '0;
            vlo_flag     <= '0;
            ok_led_en    <= 1'b0;
            fault_led_en <= 1'b0;
        end else begin
            relay_en     <= on_nxt;
            lockout      <= lock_nxt;
            vhi_flag     <= vhi_nxt;
            vlo_flag     <= vlo_nxt;
            ok_led_en    <= &on_nxt;
            fault_led_en <= |fault_nxt;
        end
    end

endmodule
